// File: rtl/axi_ram_port_bridge_pkg.sv
// axi_ram_pkg: shared types for the AXI-to-RAM-port bridge.
package axi_ram_pkg;
  localparam int MAX_ID_WIDTH = 16;
  typedef enum logic [1:0] {FIXED, INCR, WRAP} burst_t;
  typedef enum logic [1:0] {OKAY, EXOKAY, SLVERR, DECERR} resp_t;
  typedef struct packed {
    logic [MAX_ID_WIDTH-1:0] id;
    logic                    last;
    logic                    err;
  } rd_tag_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_ISSUE} r_state_t;
  function automatic logic legal(input logic [2:0] size, input logic [1:0] burst, input int lsb);
    return (32'(size) == lsb) && (burst == FIXED || burst == INCR);
  endfunction
endpackage

// File: rtl/axi_ram_port_bridge_if.sv
// axi_ram_port_bridge_if: AXI4 full bus with master/slave views.
interface axi_ram_port_bridge_if #(
  parameter int AXI_WIDTH      = 128,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4
);
  logic [AXI_ID_WIDTH-1:0]   awid, bid, arid, rid;
  logic [AXI_ADDR_WIDTH-1:0] awaddr, araddr;
  logic [7:0]                awlen, arlen;
  logic [2:0]                awsize, arsize;
  logic [1:0]                awburst, arburst, bresp, rresp;
  logic [AXI_WIDTH-1:0]      wdata, rdata;
  logic [AXI_WIDTH/8-1:0]    wstrb;
  logic                      awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic                      arvalid, arready, rlast, rvalid, rready;
  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_ram_port_bridge_rd_fifo.sv
// axi_ram_rd_fifo: two-entry FIFO of read tags and data feeding the R channel.
module axi_ram_rd_fifo import axi_ram_pkg::*; #(
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic          pop,
  input  rd_tag_t       push_tag,
  input  logic [DW-1:0] push_data,
  output rd_tag_t       head_tag,
  output logic [DW-1:0] head_data,
  output logic [1:0]    count
);
  rd_tag_t       tag_q [2];
  logic [DW-1:0] data_q [2];
  logic          wp, rp;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        tag_q[wp]  <= push_tag;
        data_q[wp] <= push_data;
        wp         <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + 2'(push) - 2'(pop);
    end
  end
  assign head_tag  = tag_q[rp];
  assign head_data = data_q[rp];
endmodule

// File: rtl/axi_ram_port_bridge.sv
// axi_ram_port_bridge: AXI4 slave turning bursts into word-addressed RAM read/write ports.
module axi_ram_port_bridge import axi_ram_pkg::*; #(
  parameter int AXI_WIDTH      = 128,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4
) (
  input  logic                                             clk,
  input  logic                                             rstn,
  axi_ram_port_bridge_if.slave                             s_axi,
  output logic                                             mm2s_ren,
  output logic [AXI_ADDR_WIDTH-($clog2(AXI_WIDTH)-3)-1:0]  mm2s_addr,
  input  logic [AXI_WIDTH-1:0]                             mm2s_data,
  output logic                                             s2mm_wen,
  output logic [AXI_ADDR_WIDTH-($clog2(AXI_WIDTH)-3)-1:0]  s2mm_addr,
  output logic [AXI_WIDTH-1:0]                             s2mm_data,
  output logic [AXI_WIDTH/8-1:0]                           s2mm_strb
);
  localparam int LSB = $clog2(AXI_WIDTH) - 3;
  localparam int WA  = AXI_ADDR_WIDTH - LSB;
  w_state_t                w_state, w_next;
  r_state_t                r_state, r_next;
  logic [AXI_ID_WIDTH-1:0] w_id, r_id;
  logic [WA-1:0]           w_addr, r_addr;
  logic [7:0]              w_len, w_cnt, r_len, r_cnt;
  logic                    w_err, w_incr, w_over, r_err, r_incr;
  resp_t                   b_resp;
  logic                    aw_fire, w_fire, ar_fire, rvalid_i, pop, issue, infl;
  rd_tag_t                 infl_tag, f_tag;
  logic [AXI_WIDTH-1:0]    f_data;
  logic [1:0]              f_count;
  always_comb begin
    s_axi.awready = rstn && w_state == W_IDLE;
    s_axi.wready  = rstn && w_state == W_DATA;
    s_axi.bvalid  = rstn && w_state == W_RESP;
    s_axi.bid     = w_id;
    s_axi.bresp   = b_resp;
    aw_fire       = s_axi.awvalid && s_axi.awready;
    w_fire        = s_axi.wvalid && s_axi.wready;
    w_next = (w_state == W_IDLE && aw_fire) ? W_DATA :
             (w_state == W_DATA && w_fire && s_axi.wlast) ? W_RESP :
             (w_state == W_RESP && s_axi.bready) ? W_IDLE : w_state;
  end
  always_ff @(posedge clk) w_state <= !rstn ? W_IDLE : w_next;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s2mm_wen <= 1'b0;
    end else begin
      s2mm_wen <= w_fire && !w_err && !w_over;
      if (aw_fire) begin
        w_id   <= s_axi.awid;
        w_addr <= s_axi.awaddr[AXI_ADDR_WIDTH-1:LSB];
        w_len  <= s_axi.awlen;
        w_err  <= !legal(s_axi.awsize, s_axi.awburst, LSB);
        w_incr <= s_axi.awburst == INCR;
        w_cnt  <= 8'd0;
        w_over <= 1'b0;
      end
      if (w_fire) begin
        s2mm_addr <= w_addr;
        s2mm_data <= s_axi.wdata;
        s2mm_strb <= s_axi.wstrb;
        if (w_incr) w_addr <= w_addr + WA'(1);
        if (!w_over) w_cnt <= w_cnt + 8'd1;
        // Beats after the one at index len are swallowed until wlast arrives.
        if (!w_over && w_cnt == w_len && !s_axi.wlast) w_over <= 1'b1;
        if (s_axi.wlast) b_resp <= (w_err || w_over || w_cnt != w_len) ? SLVERR : OKAY;
      end
    end
  end
  always_comb begin
    s_axi.arready = rstn && r_state == R_IDLE;
    ar_fire       = s_axi.arvalid && s_axi.arready;
    rvalid_i      = rstn && f_count != 2'd0;
    pop           = rvalid_i && s_axi.rready;
    // Slots already queued or in flight, minus the one leaving now, must stay below 2.
    issue         = rstn && r_state == R_ISSUE && (3'(f_count) + 3'(infl)) < (3'd2 + 3'(pop));
    mm2s_ren      = issue && !r_err;
    mm2s_addr     = r_addr;
    s_axi.rvalid  = rvalid_i;
    s_axi.rid     = f_tag.id[AXI_ID_WIDTH-1:0];
    s_axi.rdata   = f_data;
    s_axi.rresp   = f_tag.err ? SLVERR : OKAY;
    s_axi.rlast   = f_tag.last;
    r_next = (r_state == R_IDLE && ar_fire) ? R_ISSUE :
             (r_state == R_ISSUE && issue && r_cnt == r_len) ? R_IDLE : r_state;
  end
  always_ff @(posedge clk) r_state <= !rstn ? R_IDLE : r_next;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      infl <= 1'b0;
    end else begin
      infl     <= issue;
      infl_tag <= '{id: MAX_ID_WIDTH'(r_id), last: r_cnt == r_len, err: r_err};
      if (ar_fire) begin
        r_id   <= s_axi.arid;
        r_addr <= s_axi.araddr[AXI_ADDR_WIDTH-1:LSB];
        r_len  <= s_axi.arlen;
        r_err  <= !legal(s_axi.arsize, s_axi.arburst, LSB);
        r_incr <= s_axi.arburst == INCR;
        r_cnt  <= 8'd0;
      end
      if (issue) begin
        r_cnt <= r_cnt + 8'd1;
        if (r_incr) r_addr <= r_addr + WA'(1);
      end
    end
  end
  axi_ram_rd_fifo #(.DW(AXI_WIDTH)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (infl),
    .pop       (pop),
    .push_tag  (infl_tag),
    .push_data (infl_tag.err ? '0 : mm2s_data),
    .head_tag  (f_tag),
    .head_data (f_data),
    .count     (f_count)
  );
  logic unused_bits;
  assign unused_bits = ^{s_axi.awaddr[LSB-1:0], s_axi.araddr[LSB-1:0], f_tag.id[MAX_ID_WIDTH-1:AXI_ID_WIDTH]};
endmodule

// File: tb/tb_axi_ram_port_bridge.sv
// tb_axi_ram_port_bridge: directed checks of the AXI-to-RAM-port bridge against a RAM model.
module tb_axi_ram_port_bridge;
  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         mm2s_ren, s2mm_wen;
  logic [27:0]  mm2s_addr, s2mm_addr;
  logic [127:0] mm2s_data = '0;
  logic [127:0] s2mm_data;
  logic [15:0]  s2mm_strb;
  int           checks = 0, errors = 0;
  int           cyc = 0, wn = 0, renc = 0, outst = 0, maxo = 0;
  logic [27:0]  wl_addr [16];
  logic [127:0] wl_data [16];
  logic [127:0] mem [256];
  int           nb, ar_cyc;
  logic [127:0] rb_data [8];
  logic [1:0]   rb_resp [8];
  logic         rb_last [8];
  logic [3:0]   rb_id [8];
  int           rb_cyc [8];

  axi_ram_port_bridge_if #(.AXI_WIDTH(128), .AXI_ADDR_WIDTH(32), .AXI_ID_WIDTH(4)) bus ();

  axi_ram_port_bridge #(.AXI_WIDTH(128), .AXI_ADDR_WIDTH(32), .AXI_ID_WIDTH(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .s_axi     (bus),
    .mm2s_ren  (mm2s_ren),
    .mm2s_addr (mm2s_addr),
    .mm2s_data (mm2s_data),
    .s2mm_wen  (s2mm_wen),
    .s2mm_addr (s2mm_addr),
    .s2mm_data (s2mm_data),
    .s2mm_strb (s2mm_strb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mm2s_ren) begin
      mm2s_data <= mem[mm2s_addr[7:0]];
      renc <= renc + 1;
    end
    if (s2mm_wen)
      for (int b = 0; b < 16; b++)
        if (s2mm_strb[b]) mem[s2mm_addr[7:0]][b*8 +: 8] <= s2mm_data[b*8 +: 8];
    outst <= !rstn ? 0 : outst + int'(mm2s_ren) - int'(bus.rvalid && bus.rready);
  end

  always @(negedge clk) begin
    if (outst > maxo) maxo = outst;
    if (s2mm_wen && wn < 16) begin
      wl_addr[wn] = s2mm_addr;
      wl_data[wn] = s2mm_data;
    end
    if (s2mm_wen) wn++;
  end

  function automatic logic [127:0] wd(input int i);
    return {32'hAAAA_0000 + 32'(i), 32'hBBBB_0000 + 32'(i), 32'hCCCC_0000 + 32'(i), 32'hDDDD_0000 + 32'(i)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b, input logic [3:0] id);
    bus.awaddr = a; bus.awlen = l; bus.awsize = s; bus.awburst = b; bus.awid = id; bus.awvalid = 1'b1;
    for (int k = 0; k < 50 && !bus.awready; k++) tick();
    chk("aw_handshake", bus.awready, 1'b1);
    tick();
    bus.awvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b, input logic [3:0] id);
    bus.araddr = a; bus.arlen = l; bus.arsize = s; bus.arburst = b; bus.arid = id; bus.arvalid = 1'b1;
    for (int k = 0; k < 50 && !bus.arready; k++) tick();
    chk("ar_handshake", bus.arready, 1'b1);
    tick();
    ar_cyc = cyc;
    bus.arvalid = 1'b0;
  endtask

  task automatic w_burst(input int n, input int last_idx);
    for (int i = 0; i < n; i++) begin
      bus.wdata = wd(i); bus.wstrb = '1; bus.wlast = (i == last_idx); bus.wvalid = 1'b1;
      for (int k = 0; k < 50 && !bus.wready; k++) tick();
      chk("w_handshake", bus.wready, 1'b1);
      tick();
    end
    bus.wvalid = 1'b0;
    bus.wlast = 1'b0;
  endtask

  task automatic b_recv(input logic [3:0] id, input logic [1:0] resp);
    bus.bready = 1'b1;
    for (int k = 0; k < 50 && !bus.bvalid; k++) tick();
    chk("bvalid", bus.bvalid, 1'b1);
    chk("bid", bus.bid, id);
    chk("bresp", bus.bresp, resp);
    tick();
    bus.bready = 1'b0;
  endtask

  task automatic r_collect(input int n, input logic toggle);
    nb = 0;
    for (int k = 0; k < 200 && nb < n; k++) begin
      bus.rready = toggle ? (k % 2 == 0) : 1'b1;
      if (bus.rvalid && bus.rready) begin
        rb_data[nb] = bus.rdata; rb_resp[nb] = bus.rresp; rb_last[nb] = bus.rlast;
        rb_id[nb] = bus.rid; rb_cyc[nb] = cyc;
        nb++;
      end
      tick();
    end
    bus.rready = 1'b0;
    chk("r_beats", nb, n);
  endtask

  initial begin
    int w0, r0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    bus.awvalid = 0; bus.wvalid = 0; bus.bready = 0; bus.arvalid = 0; bus.rready = 0;
    bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
    bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0;
    bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", bus.awready, 1'b0);
    chk("rst_arready", bus.arready, 1'b0);
    chk("rst_rvalid", bus.rvalid, 1'b0);
    chk("rst_bvalid", bus.bvalid, 1'b0);
    chk("rst_wen", s2mm_wen, 1'b0);
    chk("rst_ren", mm2s_ren, 1'b0);
    rstn = 1'b1;
    tick();
    chk("idle_awready", bus.awready, 1'b1);
    chk("idle_arready", bus.arready, 1'b1);

    // Four-beat INCR write at 0x100.
    aw_send(32'h100, 8'd3, 3'd4, 2'd1, 4'd5);
    w_burst(4, 3);
    b_recv(4'd5, 2'd0);
    chk("t1_wen_count", wn, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_waddr", wl_addr[i], 28'h10 + 28'(i));
      chk("t1_wdata", wl_data[i], wd(i));
    end

    // Read it back at full rate.
    ar_send(32'h100, 8'd3, 3'd4, 2'd1, 4'd7);
    r_collect(4, 1'b0);
    chk("t2_latency", rb_cyc[0] - ar_cyc, 2);
    chk("t2_rate", rb_cyc[3] - rb_cyc[0], 3);
    for (int i = 0; i < 4; i++) begin
      chk("t2_rdata", rb_data[i], wd(i));
      chk("t2_rid", rb_id[i], 4'd7);
      chk("t2_rlast", rb_last[i], i == 3);
      chk("t2_rresp", rb_resp[i], 2'd0);
    end

    // Same read with rready toggling.
    maxo = 0; r0 = renc;
    ar_send(32'h100, 8'd3, 3'd4, 2'd1, 4'd2);
    r_collect(4, 1'b1);
    for (int i = 0; i < 4; i++) chk("t3_rdata", rb_data[i], wd(i));
    chk("t3_rlast", rb_last[3], 1'b1);
    chk("t3_outstanding", maxo <= 2, 1'b1);
    chk("t3_ren_count", renc - r0, 4);

    // Illegal size read and WRAP write.
    r0 = renc;
    ar_send(32'h100, 8'd1, 3'd2, 2'd1, 4'd4);
    r_collect(2, 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk("t4_rdata", rb_data[i], 128'h0);
      chk("t4_rresp", rb_resp[i], 2'd2);
    end
    chk("t4_rlast", rb_last[1], 1'b1);
    chk("t4_no_ren", renc - r0, 0);
    w0 = wn;
    aw_send(32'h200, 8'd0, 3'd4, 2'd2, 4'd3);
    w_burst(1, 0);
    b_recv(4'd3, 2'd2);
    chk("t4_no_wen", wn - w0, 0);

    // Early and late wlast.
    w0 = wn;
    aw_send(32'h300, 8'd3, 3'd4, 2'd1, 4'd1);
    w_burst(2, 1);
    b_recv(4'd1, 2'd2);
    chk("t5_early_wen", wn - w0, 2);
    w0 = wn;
    aw_send(32'h400, 8'd1, 3'd4, 2'd1, 4'd2);
    w_burst(4, 3);
    b_recv(4'd2, 2'd2);
    chk("t5_late_wen", wn - w0, 2);
    chk("t5_late_addr", wl_addr[w0 + 1], 28'h41);

    // Reset in the middle of a stalled read burst.
    ar_send(32'h100, 8'd3, 3'd4, 2'd1, 4'd6);
    repeat (3) tick();
    chk("t6_pre_rvalid", bus.rvalid, 1'b1);
    rstn = 1'b0;
    tick();
    chk("t6_rst_rvalid", bus.rvalid, 1'b0);
    chk("t6_rst_arready", bus.arready, 1'b0);
    rstn = 1'b1;
    tick();
    ar_send(32'h110, 8'd1, 3'd4, 2'd1, 4'd9);
    r_collect(2, 1'b0);
    chk("t6_rdata0", rb_data[0], wd(1));
    chk("t6_rdata1", rb_data[1], wd(2));
    chk("t6_rid", rb_id[1], 4'd9);
    chk("t6_rlast", {rb_last[0], rb_last[1]}, 2'b01);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
